slow_read_event_ctrl: RTL and testbench

- Slow-domain consumer of the single-cycle read pulse that the fast-to-slow single-bit synchronizer produces on clk2.
- Accumulates received read events in a saturating pending counter.
- Converts each pending event into one valid/ready read request toward the slow-domain read engine, with an incrementing address, and waits for completion under a timeout.
- Errors (counter overflow, completion timeout) are reported on sticky flags.

---
 rtl/slow_read_event_pkg.sv | 21 ++
 rtl/sat_updown_counter.sv | 30 +++
 rtl/slow_read_event_ctrl.sv | 111 +++++++++++
 tb/tb_slow_read_event_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slow_read_event_pkg.sv
// Shared types and defaults for the slow-domain read event controller.
// State encoding, parameter defaults and timeout counter sizing.
package slow_read_event_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int CNT_W_DEF     = 4;
  localparam int ADDR_W_DEF    = 8;
  localparam int TO_CYCLES_DEF = 64;

  function automatic int to_cnt_w(input int to_cycles);
    int w;
    w = $clog2(to_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter holding received but unissued events.
// sat_hit flags an increment lost because the count is already at max.
module sat_updown_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk2,
  input  logic             sys_rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             sat_hit
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX = '1;

  assign sat_hit = inc & ~dec & (count == MAX);

  // count moves by one on a lone inc or dec, holds at the ends
  always_ff @(posedge clk2 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count <= '0;
    end else if (inc && !dec && count != MAX) begin
      count <= count + ONE;
    end else if (!inc && dec && count != '0) begin
      count <= count - ONE;
    end
  end

endmodule

// File: rtl/slow_read_event_ctrl.sv
// Turns synchronized read pulses into valid/ready read requests
// with incrementing address, completion timeout and sticky errors.
module slow_read_event_ctrl
  import slow_read_event_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic              clk2,
  input  logic              sys_rst_n,
  input  logic              read_pulse,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic [CNT_W-1:0]  pending,
  output logic              busy,
  output logic              overflow,
  output logic              timeout_err,
  input  logic              clr_err
);

  localparam int TW = to_cnt_w(TO_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE = TW'(1);
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

  state_t        state;
  logic [TW-1:0] tcnt;
  logic          accept;
  logic          sat_hit;
  logic          to_hit;

  assign accept = rd_req_valid & rd_req_ready;
  // a completion on the last cycle beats the timeout
  assign to_hit = (state == WAIT) & ~rd_done & (tcnt == TO_LAST);

  sat_updown_counter #(
    .CNT_W(CNT_W)
  ) u_pending (
    .clk2     (clk2),
    .sys_rst_n(sys_rst_n),
    .inc      (read_pulse),
    .dec      (accept),
    .count    (pending),
    .sat_hit  (sat_hit)
  );

  // request sequencer: issue one request per pending event
  always_ff @(posedge clk2 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      rd_req_valid <= 1'b0;
      rd_addr      <= '0;
      busy         <= 1'b0;
      tcnt         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pending != '0) begin
            state        <= REQ;
            rd_req_valid <= 1'b1;
            busy         <= 1'b1;
          end
        end
        REQ: begin
          if (rd_req_ready) begin
            state        <= WAIT;
            rd_req_valid <= 1'b0;
            rd_addr      <= rd_addr + A_ONE;
            tcnt         <= '0;
          end
        end
        WAIT: begin
          if (rd_done || to_hit) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            tcnt <= tcnt + T_ONE;
          end
        end
        default: begin
          state        <= IDLE;
          rd_req_valid <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

  // sticky error flags; a new error beats a clear
  always_ff @(posedge clk2 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (sat_hit) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (to_hit) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_slow_read_event_ctrl.sv
// Bench for slow_read_event_ctrl: vector table, corner sequences
// and randomized traffic against an event-level reference model.
module tb_slow_read_event_ctrl;

  localparam int CNT_W     = 4;
  localparam int ADDR_W    = 2;
  localparam int TO_CYCLES = 64;
  localparam int PMAX      = (1 << CNT_W) - 1;
  localparam int AMOD      = 1 << ADDR_W;

  logic              clk2 = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              read_pulse = 1'b0;
  logic              rd_req_ready = 1'b0;
  logic              rd_done = 1'b0;
  logic              clr_err = 1'b0;
  logic              rd_req_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  pending;
  logic              busy;
  logic              overflow;
  logic              timeout_err;

  int checks = 0;
  int passed = 0;

  // reference model: events owed, whether a request is on offer,
  // whether one is outstanding, and how long it has been outstanding
  int m_owed, m_addr, m_age;
  bit m_offer, m_out, m_ovf, m_to;

  typedef struct {
    bit p, r, d, c;
    bit v;
    int a;
    int pe;
    bit b, o, t;
  } vec_t;

  vec_t tbl[16];

  slow_read_event_ctrl #(
    .CNT_W    (CNT_W),
    .ADDR_W   (ADDR_W),
    .TO_CYCLES(TO_CYCLES)
  ) dut (
    .clk2        (clk2),
    .sys_rst_n   (sys_rst_n),
    .read_pulse  (read_pulse),
    .rd_req_valid(rd_req_valid),
    .rd_req_ready(rd_req_ready),
    .rd_addr     (rd_addr),
    .rd_done     (rd_done),
    .pending     (pending),
    .busy        (busy),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .clr_err     (clr_err)
  );

  always #5 clk2 = ~clk2;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int pack(bit v, int a, int pe, bit b, bit o, bit t);
    logic [ADDR_W+CNT_W+3:0] x;
    x = {v, ADDR_W'(a), CNT_W'(pe), b, o, t};
    return int'(x);
  endfunction

  function automatic int dut_vec();
    return pack(rd_req_valid, int'(rd_addr), int'(pending),
                busy, overflow, timeout_err);
  endfunction

  function automatic int model_vec();
    return pack(m_offer, m_addr, m_owed, m_offer | m_out, m_ovf, m_to);
  endfunction

  function automatic vec_t mk(bit p, bit r, bit d, bit c, bit v,
                              int a, int pe, bit b, bit o, bit t);
    vec_t x;
    x.p = p; x.r = r; x.d = d; x.c = c;
    x.v = v; x.a = a; x.pe = pe; x.b = b; x.o = o; x.t = t;
    return x;
  endfunction

  task automatic model_reset();
    m_owed = 0; m_addr = 0; m_age = 0;
    m_offer = 0; m_out = 0; m_ovf = 0; m_to = 0;
  endtask

  // one clk2 edge of the reference, using the inputs now applied
  task automatic model_step();
    bit taken, lost, late;
    int owed_next;
    taken = m_offer && rd_req_ready;
    lost = 0;
    late = 0;
    owed_next = m_owed;
    if (read_pulse && !taken) begin
      if (m_owed == PMAX) lost = 1;
      else owed_next = m_owed + 1;
    end else if (!read_pulse && taken) begin
      owed_next = m_owed - 1;
    end
    if (m_out) begin
      if (rd_done) m_out = 0;
      else if (m_age == TO_CYCLES - 1) begin
        m_out = 0;
        late = 1;
      end else m_age++;
    end else if (m_offer) begin
      if (taken) begin
        m_offer = 0;
        m_out = 1;
        m_age = 0;
        m_addr = (m_addr + 1) % AMOD;
      end
    end else if (m_owed > 0) begin
      m_offer = 1;
    end
    m_owed = owed_next;
    m_ovf = lost | (m_ovf & !clr_err);
    m_to = late | (m_to & !clr_err);
  endtask

  task automatic drive(bit p, bit r, bit d, bit c);
    read_pulse = p;
    rd_req_ready = r;
    rd_done = d;
    clr_err = c;
  endtask

  task automatic step();
    model_step();
    @(posedge clk2);
    #1;
    chk("cycle", dut_vec(), model_vec());
  endtask

  initial begin
    int n, a0;
    bit seen;

    // pulse, ready, done, clr | valid, addr, pending, busy, ovf, to
    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 1, 0, 1, 1, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 1, 0, 1, 0, 0);
    tbl[3]  = mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 0, 1, 1, 2, 1, 0, 0);
    tbl[7]  = mk(1, 1, 0, 0, 0, 2, 2, 1, 0, 0);
    tbl[8]  = mk(0, 0, 1, 0, 0, 2, 2, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 1, 2, 2, 1, 0, 0);
    tbl[10] = mk(0, 1, 0, 0, 0, 3, 1, 1, 0, 0);
    tbl[11] = mk(0, 1, 0, 0, 0, 3, 1, 1, 0, 0);
    tbl[12] = mk(0, 0, 1, 0, 0, 3, 1, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 1, 3, 1, 1, 0, 0);
    tbl[14] = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[15] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    model_reset();
    repeat (2) @(posedge clk2);
    #1;
    chk("reset_state", dut_vec(), 0);
    @(negedge clk2);
    sys_rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].p, tbl[i].r, tbl[i].d, tbl[i].c);
      step();
      chk($sformatf("table_row%0d", i), dut_vec(),
          pack(tbl[i].v, tbl[i].a, tbl[i].pe, tbl[i].b, tbl[i].o, tbl[i].t));
    end

    // burst under backpressure, then drain with done after each accept
    drive(1, 0, 0, 0);
    repeat (5) step();
    drive(0, 0, 0, 0);
    chk("burst_pending", int'(pending), 5);
    chk("burst_valid", int'(rd_req_valid), 1);
    a0 = int'(rd_addr);
    repeat (3) step();
    chk("burst_addr_stable", int'(rd_addr), a0);
    drive(0, 1, 1, 0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (rd_req_valid && rd_req_ready) begin
        chk($sformatf("burst_addr%0d", n), int'(rd_addr), n % AMOD);
        n++;
      end
      step();
      if (n == 5 && !busy && pending == '0) break;
    end
    chk("burst_handshakes", n, 5);
    chk("burst_drained", int'(pending), 0);

    // saturation of the pending counter
    drive(1, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 15) begin
        chk("sat_pending15", int'(pending), PMAX);
        chk("sat_no_ovf_yet", int'(overflow), 0);
      end
    end
    chk("sat_pending16", int'(pending), PMAX);
    chk("sat_ovf", int'(overflow), 1);
    drive(0, 0, 0, 1);
    step();
    chk("clr_ovf", int'(overflow), 0);
    chk("clr_keeps_pending", int'(pending), PMAX);
    drive(1, 0, 0, 1);
    step();
    chk("set_beats_clr", int'(overflow), 1);
    drive(0, 0, 0, 1);
    step();
    drive(0, 1, 1, 0);
    for (int k = 0; k < 100; k++) begin
      if (!busy && pending == '0) break;
      step();
    end
    chk("sat_drained", int'(busy | (pending != '0)), 0);

    // timeout, then next pending request goes out
    drive(1, 1, 0, 0);
    step();
    step();
    drive(0, 1, 0, 0);
    step();
    chk("to_accepted", int'(rd_req_valid), 0);
    n = 0;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      n++;
      if (timeout_err) begin
        seen = 1;
        break;
      end
    end
    chk("to_seen", int'(seen), 1);
    chk("to_latency", n, TO_CYCLES);
    chk("to_idle", int'(busy), 0);
    step();
    chk("to_next_req", int'(rd_req_valid), 1);

    // done on the very last cycle wins over the timeout
    drive(0, 1, 0, 1);
    step();
    chk("to_cleared", int'(timeout_err), 0);
    drive(0, 0, 0, 0);
    repeat (TO_CYCLES - 1) step();
    chk("edge_still_busy", int'(busy), 1);
    drive(0, 0, 1, 0);
    step();
    chk("edge_no_to", int'(timeout_err), 0);
    chk("edge_idle", int'(busy), 0);

    // asynchronous reset while a request is on offer
    drive(1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0);
    step();
    chk("pre_rst_valid", int'(rd_req_valid), 1);
    @(negedge clk2);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("async_rst", dut_vec(), 0);
    model_reset();
    @(posedge clk2);
    @(negedge clk2);
    sys_rst_n = 1'b1;
    step();

    // randomized traffic against the model
    for (int ph = 0; ph < 6; ph++) begin
      for (int k = 0; k < 500; k++) begin
        drive(($urandom_range(3) == 0),
              ($urandom_range(1) == 0),
              (ph % 2 == 0) ? ($urandom_range(4) < 2)
                            : ($urandom_range(99) == 0),
              ($urandom_range(15) == 0));
        step();
      end
    end

    drive(0, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
